tcm_dport_arbiter: RTL and testbench
====================================

Name:
tcm_dport_arbiter

Overview:
- Shares the single TCM data port (mem_d_* request/ack interface of tcm_mem) between two requesters: m0 is the core LSU, m1 is a DMA/debug loader that writes program images and polls result words.
- Sits between riscv_core, the loader, and tcm_mem.
- Arbitrates requests, holds a grant until the TCM accepts it, and steers in-order acks back to the originating master via an ID FIFO.
- Response data and tag are taken by both masters directly from the TCM response bus; only ack is steered.

Parameters:
- OUTSTANDING, 2: max accepted-but-unacked requests (power of 2, >=1); depth of the ID FIFO.
- M0_FIXED_PRIO, 0: 0 = round-robin between masters; 1 = m0 always wins ties.

Ports:
clk  in  1  clock
rst  in  1  reset
m0_addr_i  in  32  m0 byte address
m0_data_wr_i  in  32  m0 write data
m0_rd_i  in  1  m0 read request
m0_wr_i  in  4  m0 byte write strobes
m0_req_tag_i  in  11  m0 request tag
m0_accept_o  out  1  m0 request accepted this cycle
m0_ack_o  out  1  response for m0 valid this cycle
m1_addr_i  in  32  m1 byte address
m1_data_wr_i  in  32  m1 write data
m1_rd_i  in  1  m1 read request
m1_wr_i  in  4  m1 byte write strobes
m1_req_tag_i  in  11  m1 request tag
m1_accept_o  out  1  m1 request accepted this cycle
m1_ack_o  out  1  response for m1 valid this cycle
s_addr_o  out  32  to TCM: address of granted master
s_data_wr_o  out  32  to TCM: write data
s_rd_o  out  1  to TCM: read request
s_wr_o  out  4  to TCM: write strobes
s_req_tag_o  out  11  to TCM: request tag
s_accept_i  in  1  TCM accepts presented request
s_ack_i  in  1  TCM response valid (in request order)
outstanding_o  out  $clog2(OUTSTANDING)+1  current ID FIFO occupancy
unexp_ack_o  out  1  sticky: ack received with ID FIFO empty

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. On reset, all outputs are 0, the FIFO is empty, lock_q=0, and last_q=1 (m0 wins the first tie).
- Request: req_n = mN_rd_i | (|mN_wr_i).
- Grant (combinational, from registered state):
  - If lock_q, grant lock_id_q.
  - Otherwise, if only one master requests, grant it.
  - If both request: with M0_FIXED_PRIO=1, grant m0; otherwise grant ~last_q.
- s_* outputs mux the granted master. s_rd_o and s_wr_o are 0 if there is no grant or the FIFO is full (outstanding_o==OUTSTANDING).
- Transfer: fire = (s_rd_o | |s_wr_o) & s_accept_i. The granted mN_accept_o = fire; the other master's accept is 0.
  - On fire: push the granted ID, set last_q=ID, clear lock_q.
- Presented but not accepted (or blocked by full FIFO): set lock_q=1 and lock_id_q=granted ID. The grant must not switch until the transfer fires. Masters hold requests stable until accepted.
- Lock release: if the locked master drops its request without being accepted, lock_q clears the next cycle. This is a protocol violation; no other action is taken.
- Ack: on s_ack_i with FIFO non-empty, pop the head and assert mHEAD_ack_o=1 in the same cycle (combinational from s_ack_i). Acks are mutually exclusive.
- Ack with FIFO empty: both acks stay 0, unexp_ack_o is set and held until reset.
- Simultaneous push and pop: occupancy is unchanged, FIFO order is preserved, and the head is read before the push.
- Full FIFO: the new request is blocked even if a pop occurs in the same cycle.
- Pointers wrap modulo OUTSTANDING. outstanding_o is registered (push/pop count) and never exceeds OUTSTANDING.
- Reset mid-transaction: in-flight IDs are discarded. A later stale s_ack_i sets unexp_ack_o.
- Latency: request to s_* is 0 cycles; ack steering is 0 cycles; arbitration state updates on the next clk edge.

Test Plan:
- Single master: m0 reads addr 0x80009030, s_accept_i=1, s_ack_i one cycle later -> m0_accept_o=1 at cycle 0, m0_ack_o=1 at cycle 1, m1_ack_o=0, outstanding_o goes 1 then 0.
- Round-robin: both masters request continuously, TCM always accepts -> grants alternate m0,m1,m0,m1 starting with m0. With M0_FIXED_PRIO=1, grants are m0 every cycle.
- Lock: m1 granted with s_accept_i=0 for 3 cycles while m0 also requests -> s_addr_o stays at m1's address; m1_accept_o rises on cycle 4; m0 is granted next.
- Full/in-order: OUTSTANDING=2; m0 then m1 accepted with no ack -> third request blocked (s_rd_o=0). Two acks then return m0_ack_o followed by m1_ack_o.
- Simultaneous push/pop at occupancy 1 -> outstanding_o stays 1; the ack goes to the older ID.
- Stale ack: assert rst low mid-flight with 1 outstanding, release it, pulse s_ack_i -> no mN_ack_o and unexp_ack_o=1 until the next reset.

Source files
------------

// File: rtl/tcm_dport_arbiter.sv
// Two-master arbiter for the single TCM data port. It holds a grant until the TCM accepts it
// and uses an in-order ID FIFO to steer each ack back to the master that issued the request.
module tcm_dport_arbiter #(
   parameter int OUTSTANDING   = 2,
   parameter bit M0_FIXED_PRIO = 1'b0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [31:0]                    m0_addr_i,
   input  logic [31:0]                    m0_data_wr_i,
   input  logic                           m0_rd_i,
   input  logic [3:0]                     m0_wr_i,
   input  logic [10:0]                    m0_req_tag_i,
   output logic                           m0_accept_o,
   output logic                           m0_ack_o,
   input  logic [31:0]                    m1_addr_i,
   input  logic [31:0]                    m1_data_wr_i,
   input  logic                           m1_rd_i,
   input  logic [3:0]                     m1_wr_i,
   input  logic [10:0]                    m1_req_tag_i,
   output logic                           m1_accept_o,
   output logic                           m1_ack_o,
   output logic [31:0]                    s_addr_o,
   output logic [31:0]                    s_data_wr_o,
   output logic                           s_rd_o,
   output logic [3:0]                     s_wr_o,
   output logic [10:0]                    s_req_tag_o,
   input  logic                           s_accept_i,
   input  logic                           s_ack_i,
   output logic [$clog2(OUTSTANDING):0]   outstanding_o,
   output logic                           unexp_ack_o
);
   localparam int CW = $clog2(OUTSTANDING) + 1;
   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

   logic [OUTSTANDING-1:0] fifo_q, fifo_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   lock_q, lock_d, lock_id_q, lock_id_d;
   logic                   last_q, last_d, unexp_q, unexp_d;
   logic                   req0, req1, gnt_vld, gnt_id, full, empty, fire, pop, head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(OUTSTANDING - 1)) return '0;
      return p + PW'(1);
   endfunction

   assign full  = (cnt_q == CW'(OUTSTANDING));
   assign empty = (cnt_q == '0);

   always_comb begin
      req0    = m0_rd_i | (|m0_wr_i);
      req1    = m1_rd_i | (|m1_wr_i);
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (lock_q) begin
         gnt_id  = lock_id_q;
         gnt_vld = lock_id_q ? req1 : req0;
      end else if (req0 & req1) begin
         gnt_vld = 1'b1;
         gnt_id  = M0_FIXED_PRIO ? 1'b0 : ~last_q;
      end else begin
         gnt_vld = req0 | req1;
         gnt_id  = req1 & ~req0;
      end
   end

   // A full FIFO only masks the strobes; the request stays visible and the grant locks.
   always_comb begin
      s_addr_o    = '0;
      s_data_wr_o = '0;
      s_rd_o      = 1'b0;
      s_wr_o      = '0;
      s_req_tag_o = '0;
      if (gnt_vld) begin
         s_addr_o    = gnt_id ? m1_addr_i    : m0_addr_i;
         s_data_wr_o = gnt_id ? m1_data_wr_i : m0_data_wr_i;
         s_req_tag_o = gnt_id ? m1_req_tag_i : m0_req_tag_i;
         s_rd_o      = ~full & (gnt_id ? m1_rd_i : m0_rd_i);
         s_wr_o      = full ? 4'b0 : (gnt_id ? m1_wr_i : m0_wr_i);
      end
   end

   assign fire        = (s_rd_o | (|s_wr_o)) & s_accept_i;
   assign m0_accept_o = fire & ~gnt_id;
   assign m1_accept_o = fire & gnt_id;

   assign pop           = s_ack_i & ~empty;
   assign head          = fifo_q[rd_ptr_q];
   assign m0_ack_o      = pop & ~head;
   assign m1_ack_o      = pop & head;
   assign outstanding_o = cnt_q;
   assign unexp_ack_o   = unexp_q;

   always_comb begin
      fifo_d    = fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q + CW'(fire) - CW'(pop);
      last_d    = fire ? gnt_id : last_q;
      lock_d    = ~fire & gnt_vld;
      lock_id_d = gnt_id;
      unexp_d   = unexp_q | (s_ack_i & empty);
      if (fire) begin
         fifo_d[wr_ptr_q] = gnt_id;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         last_q    <= 1'b1;
         unexp_q   <= 1'b0;
      end else begin
         fifo_q    <= fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         last_q    <= last_d;
         unexp_q   <= unexp_d;
      end
   end
endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// Bench for tcm_dport_arbiter: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic including resets and stale acks.
module tb_tcm_dport_arbiter;
   localparam int OUT = 2;
   localparam bit FIX = 1'b0;
   localparam int CW  = $clog2(OUT) + 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        rd;
      logic [3:0]  wr;
      logic [10:0] tag;
   } mreq_t;

   logic clk = 1'b0, rst = 1'b0;
   logic [31:0] m0_addr_i, m0_data_wr_i, m1_addr_i, m1_data_wr_i;
   logic        m0_rd_i, m1_rd_i, s_accept_i, s_ack_i;
   logic [3:0]  m0_wr_i, m1_wr_i;
   logic [10:0] m0_req_tag_i, m1_req_tag_i;
   logic        m0_accept_o, m0_ack_o, m1_accept_o, m1_ack_o, s_rd_o, unexp_ack_o;
   logic [31:0] s_addr_o, s_data_wr_o;
   logic [3:0]  s_wr_o;
   logic [10:0] s_req_tag_o;
   logic [CW-1:0] outstanding_o;
   // fixed-priority instance, only its accepts are inspected
   logic        f_m0_accept, f_m0_ack, f_m1_accept, f_m1_ack, f_s_rd, f_unexp;
   logic [31:0] f_s_addr, f_s_data;
   logic [3:0]  f_s_wr;
   logic [10:0] f_s_tag;
   logic [CW-1:0] f_out;

   always #5 clk = ~clk;

   tcm_dport_arbiter #(.OUTSTANDING(OUT), .M0_FIXED_PRIO(FIX)) dut (
      .clk(clk), .rst(rst),
      .m0_addr_i(m0_addr_i), .m0_data_wr_i(m0_data_wr_i), .m0_rd_i(m0_rd_i), .m0_wr_i(m0_wr_i),
      .m0_req_tag_i(m0_req_tag_i), .m0_accept_o(m0_accept_o), .m0_ack_o(m0_ack_o),
      .m1_addr_i(m1_addr_i), .m1_data_wr_i(m1_data_wr_i), .m1_rd_i(m1_rd_i), .m1_wr_i(m1_wr_i),
      .m1_req_tag_i(m1_req_tag_i), .m1_accept_o(m1_accept_o), .m1_ack_o(m1_ack_o),
      .s_addr_o(s_addr_o), .s_data_wr_o(s_data_wr_o), .s_rd_o(s_rd_o), .s_wr_o(s_wr_o),
      .s_req_tag_o(s_req_tag_o), .s_accept_i(s_accept_i), .s_ack_i(s_ack_i),
      .outstanding_o(outstanding_o), .unexp_ack_o(unexp_ack_o));

   tcm_dport_arbiter #(.OUTSTANDING(OUT), .M0_FIXED_PRIO(1'b1)) dut_fix (
      .clk(clk), .rst(rst),
      .m0_addr_i(m0_addr_i), .m0_data_wr_i(m0_data_wr_i), .m0_rd_i(m0_rd_i), .m0_wr_i(m0_wr_i),
      .m0_req_tag_i(m0_req_tag_i), .m0_accept_o(f_m0_accept), .m0_ack_o(f_m0_ack),
      .m1_addr_i(m1_addr_i), .m1_data_wr_i(m1_data_wr_i), .m1_rd_i(m1_rd_i), .m1_wr_i(m1_wr_i),
      .m1_req_tag_i(m1_req_tag_i), .m1_accept_o(f_m1_accept), .m1_ack_o(f_m1_ack),
      .s_addr_o(f_s_addr), .s_data_wr_o(f_s_data), .s_rd_o(f_s_rd), .s_wr_o(f_s_wr),
      .s_req_tag_o(f_s_tag), .s_accept_i(s_accept_i), .s_ack_i(s_ack_i),
      .outstanding_o(f_out), .unexp_ack_o(f_unexp));

   int n_cmp = 0, n_bad = 0;
   int q[$];
   bit m_lk, m_unexp, e_gv, e_fire, e_pop;
   int m_lkid, m_last, e_g;
   mreq_t idle;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete(); m_lk = 0; m_lkid = 0; m_last = 1; m_unexp = 0;
   endfunction

   task automatic model_check();
      mreq_t a0, a1, g;
      bit r0, r1, go, exp_rd;
      logic [3:0] exp_wr;
      if (!rst) model_reset();
      a0 = '{m0_addr_i, m0_data_wr_i, m0_rd_i, m0_wr_i, m0_req_tag_i};
      a1 = '{m1_addr_i, m1_data_wr_i, m1_rd_i, m1_wr_i, m1_req_tag_i};
      r0 = a0.rd || a0.wr != 0;
      r1 = a1.rd || a1.wr != 0;
      if (m_lk) begin
         e_g = m_lkid; e_gv = (e_g == 0) ? r0 : r1;
      end else if (r0 && r1) begin
         e_gv = 1; e_g = FIX ? 0 : 1 - m_last;
      end else begin
         e_gv = r0 || r1; e_g = (r1 && !r0) ? 1 : 0;
      end
      g      = (e_g == 1) ? a1 : a0;
      go     = e_gv && (q.size() < OUT);
      exp_rd = go && g.rd;
      exp_wr = go ? g.wr : 4'd0;
      e_fire = (exp_rd || exp_wr != 0) && s_accept_i;
      e_pop  = s_ack_i && q.size() > 0;
      chk("s_addr", s_addr_o, e_gv ? g.addr : 32'd0);
      chk("s_data", s_data_wr_o, e_gv ? g.data : 32'd0);
      chk("s_tag", s_req_tag_o, e_gv ? 32'(g.tag) : 32'd0);
      chk("s_rd", s_rd_o, exp_rd);
      chk("s_wr", s_wr_o, exp_wr);
      chk("m0_accept", m0_accept_o, e_fire && e_g == 0);
      chk("m1_accept", m1_accept_o, e_fire && e_g == 1);
      chk("m0_ack", m0_ack_o, e_pop && q[0] == 0);
      chk("m1_ack", m1_ack_o, e_pop && q[0] == 1);
      chk("outstanding", outstanding_o, q.size());
      chk("unexp_ack", unexp_ack_o, m_unexp);
   endtask

   task automatic model_update();
      if (!rst) return;
      if (s_ack_i && !e_pop) m_unexp = 1;
      if (e_pop) void'(q.pop_front());
      if (e_fire) begin q.push_back(e_g); m_last = e_g; end
      m_lk   = !e_fire && e_gv;
      m_lkid = e_g;
   endtask

   task automatic drive(input mreq_t a, input mreq_t b, input bit acc, input bit ack);
      m0_addr_i = a.addr; m0_data_wr_i = a.data; m0_rd_i = a.rd; m0_wr_i = a.wr; m0_req_tag_i = a.tag;
      m1_addr_i = b.addr; m1_data_wr_i = b.data; m1_rd_i = b.rd; m1_wr_i = b.wr; m1_req_tag_i = b.tag;
      s_accept_i = acc; s_ack_i = ack;
   endtask

   task automatic sample(); #1; model_check(); endtask
   task automatic adv(); model_update(); @(negedge clk); endtask

   task automatic do_reset();
      drive(idle, idle, 0, 0);
      rst = 1'b0;
      sample();
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_unexp", unexp_ack_o, 0);
      chk("rst_s_rd", s_rd_o, 0);
      adv();
      rst = 1'b1;
   endtask

   function automatic mreq_t rd_req(input logic [31:0] addr);
      mreq_t r;
      r = '{addr, 32'h0, 1'b1, 4'h0, 11'h0};
      return r;
   endfunction

   function automatic mreq_t rnd_req();
      mreq_t r;
      r.addr = $urandom; r.data = $urandom; r.tag = 11'($urandom);
      if ($urandom % 2 == 1) begin r.rd = 1; r.wr = 0; end
      else begin r.rd = 0; r.wr = 4'($urandom_range(1, 15)); end
      return r;
   endfunction

   initial begin
      mreq_t p0, p1;
      bit v0, v1, ack;
      idle = '{32'h0, 32'h0, 1'b0, 4'h0, 11'h0};
      drive(idle, idle, 0, 0);
      @(negedge clk);
      do_reset();

      // single master read, ack a cycle later
      drive(rd_req(32'h8000_9030), idle, 1, 0); sample();
      chk("single_accept", m0_accept_o, 1); chk("single_addr", s_addr_o, 32'h8000_9030); adv();
      drive(idle, idle, 0, 1); sample();
      chk("single_m0_ack", m0_ack_o, 1); chk("single_m1_ack", m1_ack_o, 0);
      chk("single_occ1", outstanding_o, 1); adv();
      drive(idle, idle, 0, 0); sample(); chk("single_occ0", outstanding_o, 0); adv();

      // round robin with push/pop at occupancy 1
      do_reset();
      for (int c = 0; c < 4; c++) begin
         drive(rd_req(32'hA0 + c), rd_req(32'hB0 + c), 1, c > 0); sample();
         chk("rr_m0_accept", m0_accept_o, (c % 2) == 0);
         chk("rr_m1_accept", m1_accept_o, (c % 2) == 1);
         chk("fix_m0_accept", f_m0_accept, 1);
         if (c > 0) begin
            chk("rr_occ", outstanding_o, 1);
            chk("rr_ack_older", m0_ack_o, (c % 2) == 1);
         end
         adv();
      end

      // grant lock while the TCM stalls
      do_reset();
      drive(idle, rd_req(32'h1111_0000), 0, 0); sample();
      chk("lock_addr0", s_addr_o, 32'h1111_0000); adv();
      for (int c = 1; c < 4; c++) begin
         drive(rd_req(32'h2222_0000), rd_req(32'h1111_0000), c == 3, 0); sample();
         chk("lock_addr", s_addr_o, 32'h1111_0000);
         chk("lock_m1_accept", m1_accept_o, c == 3);
         adv();
      end
      drive(rd_req(32'h2222_0000), rd_req(32'h1111_0004), 1, 0); sample();
      chk("lock_m0_next", m0_accept_o, 1); adv();

      // full FIFO and in-order acks
      do_reset();
      drive(rd_req(32'h100), idle, 1, 0); sample(); chk("full_a0", m0_accept_o, 1); adv();
      drive(idle, rd_req(32'h200), 1, 0); sample(); chk("full_a1", m1_accept_o, 1); adv();
      drive(rd_req(32'h300), idle, 1, 0); sample();
      chk("full_blk_rd", s_rd_o, 0); chk("full_occ2", outstanding_o, 2); adv();
      drive(rd_req(32'h300), idle, 1, 1); sample();
      chk("full_blk_pop", s_rd_o, 0); chk("full_ack0", m0_ack_o, 1); adv();
      drive(rd_req(32'h300), idle, 1, 1); sample();
      chk("full_ack1", m1_ack_o, 1); chk("full_fire", m0_accept_o, 1); adv();
      drive(idle, idle, 0, 0); sample(); chk("full_occ_pp", outstanding_o, 1); adv();

      // stale ack after mid-flight reset
      do_reset();
      drive(rd_req(32'h400), idle, 1, 0); sample(); adv();
      drive(idle, idle, 0, 0); sample(); chk("stale_occ", outstanding_o, 1); adv();
      do_reset();
      drive(idle, idle, 0, 1); sample();
      chk("stale_m0_ack", m0_ack_o, 0); chk("stale_m1_ack", m1_ack_o, 0); adv();
      for (int c = 0; c < 3; c++) begin
         drive(idle, idle, 0, 0); sample(); chk("stale_sticky", unexp_ack_o, 1); adv();
      end
      do_reset();

      // randomized traffic
      v0 = 0; v1 = 0; p0 = idle; p1 = idle;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom % 300 == 0) begin
            do_reset(); v0 = 0; v1 = 0; continue;
         end
         if (!v0 && $urandom % 3 == 0) begin p0 = rnd_req(); v0 = 1; end
         else if (v0 && $urandom % 64 == 0) v0 = 0;
         if (!v1 && $urandom % 3 == 0) begin p1 = rnd_req(); v1 = 1; end
         else if (v1 && $urandom % 64 == 0) v1 = 0;
         ack = (q.size() > 0) ? ($urandom % 2 == 1) : (c >= 3000 && $urandom % 10 == 0);
         drive(v0 ? p0 : idle, v1 ? p1 : idle, $urandom % 4 != 0, ack);
         sample();
         if (e_fire) begin if (e_g == 0) v0 = 0; else v1 = 0; end
         adv();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
